// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register numbers, ExcCodes and reset values.
// Timer support is selected by the CP0_TIMER_EN macro.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_SR      = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

`ifdef CP0_TIMER_EN
  localparam bit CP0_TIMER_ON = 1'b1;
`else
  localparam bit CP0_TIMER_ON = 1'b0;
`endif

  localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

  // IM resets to 1 only for pending bits that can actually be raised.
  function automatic logic [31:0] cp0_sr_reset(input int unsigned hw_int_num);
    logic [7:0] im;
    im = 8'b0000_0011;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < hw_int_num) im[i+2] = 1'b1;
    end
    if (CP0_TIMER_ON) im[7] = 1'b1;
    return {16'h0000, im, 6'b000000, 1'b0, 1'b1};
  endfunction

endpackage

// File: rtl/cp0_int_pending.sv
// Per-line hardware interrupt capture: level lines pass through, edge lines latch a 0->1
// transition until software clears them through Cause.
module cp0_int_pending #(
  parameter int unsigned HW_INT_NUM    = 6,
  parameter logic [5:0]  INT_EDGE_MASK = 6'b000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [HW_INT_NUM-1:0] i_hw_int,
  input  logic                  i_clr_en,
  input  logic [5:0]            i_clr_keep,
  output logic [5:0]            o_ip_hw
);

  logic w_unused_keep;
  assign w_unused_keep = ^i_clr_keep;

  for (genvar i = 0; i < 6; i++) begin : g_line
    if (i < HW_INT_NUM) begin : g_impl
      if (INT_EDGE_MASK[i]) begin : g_edge
        logic r_hist;
        logic r_latch;
        // A new edge beats a coincident software clear.
        always_ff @(posedge i_clk or posedge i_reset) begin
          if (i_reset) begin
            r_hist  <= 1'b0;
            r_latch <= 1'b0;
          end else begin
            r_hist  <= i_hw_int[i];
            r_latch <= (i_hw_int[i] & ~r_hist) | (r_latch & ~(i_clr_en & ~i_clr_keep[i]));
          end
        end
        assign o_ip_hw[i] = r_latch;
      end else begin : g_level
        assign o_ip_hw[i] = i_hw_int[i];
      end
    end else begin : g_none
      assign o_ip_hw[i] = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt entry, eret, and an optional
// Count/Compare timer built only when CP0_TIMER_EN is defined.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned HW_INT_NUM    = 6,
  parameter logic [5:0]  INT_EDGE_MASK = 6'b000000,
  parameter logic [31:0] PRID_VALUE    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_req,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  eret,
  output logic                  exc_take,
  output logic [31:0]           epc
);

  localparam logic [31:0] SrReset = cp0_sr_reset(HW_INT_NUM);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [7:0]  r_ip_q;
  logic [1:0]  r_sw;
  logic [31:0] r_epc;

  logic [5:0]  w_ip_hw;
  logic [7:0]  w_ip_now;
  logic        w_timer_ip;
  logic        w_int_req;
  logic        w_wr_ok;
  logic        w_wr_sr;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic [31:0] w_epc_base;
  logic [31:0] w_epc_entry;
  logic [31:0] w_count_rd;
  logic [31:0] w_compare_rd;
  logic        w_unused_pc;

  assign w_unused_pc = ^exc_pc[1:0];

  cp0_int_pending #(
    .HW_INT_NUM   (HW_INT_NUM),
    .INT_EDGE_MASK(INT_EDGE_MASK)
  ) u_int_pending (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_hw_int  (hw_int),
    .i_clr_en  (w_wr_cause),
    .i_clr_keep(wdata[15:10]),
    .o_ip_hw   (w_ip_hw)
  );

  assign w_ip_now  = {w_ip_hw[5] | w_timer_ip, w_ip_hw[4:0], r_sw};
  assign w_int_req = r_ie & |(r_im & w_ip_now);
  assign exc_take  = ~r_exl & (w_int_req | exc_req);

  // Entry and eret both take precedence over a same-cycle mtc0.
  assign w_wr_ok    = we & ~exc_take & ~eret;
  assign w_wr_sr    = w_wr_ok & (waddr == CP0_REG_SR);
  assign w_wr_cause = w_wr_ok & (waddr == CP0_REG_CAUSE);
  assign w_wr_epc   = w_wr_ok & (waddr == CP0_REG_EPC);

  assign w_epc_base  = {exc_pc[31:2], 2'b00};
  assign w_epc_entry = exc_bd ? w_epc_base - 32'd4 : w_epc_base;
  assign epc         = r_epc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im       <= SrReset[15:8];
      r_exl      <= SrReset[1];
      r_ie       <= SrReset[0];
      r_bd       <= 1'b0;
      r_exc_code <= 5'd0;
      r_ip_q     <= 8'd0;
      r_sw       <= 2'b00;
      r_epc      <= 32'd0;
    end else begin
      r_ip_q <= w_ip_now;
      if (exc_take) begin
        r_exl      <= 1'b1;
        r_bd       <= exc_bd;
        r_exc_code <= w_int_req ? EXC_INT : exc_code;
        r_epc      <= w_epc_entry;
      end else if (eret) begin
        r_exl <= 1'b0;
      end
      if (w_wr_sr) begin
        r_im  <= wdata[15:8];
        r_exl <= wdata[1];
        r_ie  <= wdata[0];
      end
      if (w_wr_cause) r_sw <= wdata[9:8];
      if (w_wr_epc) r_epc <= {wdata[31:2], 2'b00};
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_ip;
  logic        w_wr_count;
  logic        w_wr_compare;

  assign w_wr_count   = w_wr_ok & (waddr == CP0_REG_COUNT);
  assign w_wr_compare = w_wr_ok & (waddr == CP0_REG_COMPARE);

  // A Compare write clears the timer interrupt even if a match happens in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= 32'd0;
      r_compare  <= COMPARE_RESET;
      r_timer_ip <= 1'b0;
    end else begin
      r_count <= w_wr_count ? wdata : r_count + 32'd1;
      if (w_wr_compare) begin
        r_compare  <= wdata;
        r_timer_ip <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timer_ip <= 1'b1;
      end
    end
  end

  assign w_timer_ip   = r_timer_ip;
  assign w_count_rd   = r_count;
  assign w_compare_rd = r_compare;
`else
  assign w_timer_ip   = 1'b0;
  assign w_count_rd   = 32'd0;
  assign w_compare_rd = 32'd0;
`endif

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      CP0_REG_COUNT:   rdata = w_count_rd;
      CP0_REG_COMPARE: rdata = w_compare_rd;
      CP0_REG_SR:      rdata = {16'h0000, r_im, 6'b000000, r_exl, r_ie};
      CP0_REG_CAUSE:   rdata = {r_bd, w_timer_ip, 14'h0000, r_ip_q, 1'b0, r_exc_code, 2'b00};
      CP0_REG_EPC:     rdata = r_epc;
      CP0_REG_PRID:    rdata = PRID_VALUE;
      default:         rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: stimulus queues expected reads and entry cycles, a negedge
// monitor pops and compares them. Timer checks are built when CP0_TIMER_EN is defined.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic [4:0]  raddr = 5'd0;
  logic [31:0] rdata;
  logic [5:0]  hw_int = 6'd0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [31:0] exc_pc = 32'd0;
  logic        exc_bd = 1'b0;
  logic        eret = 1'b0;
  logic        exc_take;
  logic [31:0] epc;

  localparam logic [31:0] PridVal = 32'h0001_8000;
`ifdef CP0_TIMER_EN
  localparam logic [31:0] CmpRst = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CmpRst = 32'h0000_0000;
`endif

  cp0_ctrl #(
    .HW_INT_NUM   (6),
    .INT_EDGE_MASK(6'b000010),
    .PRID_VALUE   (PridVal)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata),
    .hw_int  (hw_int),
    .exc_req (exc_req),
    .exc_code(exc_code),
    .exc_pc  (exc_pc),
    .exc_bd  (exc_bd),
    .eret    (eret),
    .exc_take(exc_take),
    .epc     (epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [31:0] epc;
    bit          chk_epc;
    string       name;
  } rd_exp_t;

  typedef struct {
    int    cyc;
    string name;
  } take_exp_t;

  rd_exp_t   rd_q[$];
  take_exp_t take_q[$];
  int        n_checks = 0;
  int        n_errors = 0;
  int        cyc = 0;
  logic      rd_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rd_exp_t   r;
    take_exp_t t;
    if (rd_valid) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_underflow: read strobe with empty queue, rdata=%h", rdata);
      end else begin
        r = rd_q.pop_front();
        if (rdata !== r.val) begin
          n_errors++;
          $display("FAIL %s: rdata=%h expected %h", r.name, rdata, r.val);
        end
        if (r.chk_epc) begin
          n_checks++;
          if (epc !== r.epc) begin
            n_errors++;
            $display("FAIL %s_epc_port: epc=%h expected %h", r.name, epc, r.epc);
          end
        end
      end
    end
    if (exc_take !== 1'b0) begin
      n_checks++;
      if (take_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_take: exc_take=%b at cycle %0d expected 0", exc_take, cyc);
      end else begin
        t = take_q.pop_front();
        if (t.cyc != cyc) begin
          n_errors++;
          $display("FAIL %s: exc_take at cycle %0d expected cycle %0d", t.name, cyc, t.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    we       = 1'b0;
    exc_req  = 1'b0;
    exc_bd   = 1'b0;
    eret     = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  task automatic rd_push(input logic [4:0] a, input logic [31:0] v, input logic [31:0] ep,
                         input bit ce, input string nm);
    rd_exp_t e;
    e.val     = v;
    e.epc     = ep;
    e.chk_epc = ce;
    e.name    = nm;
    rd_q.push_back(e);
    raddr    = a;
    rd_valid = 1'b1;
    step();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
    rd_push(a, v, 32'd0, 1'b0, nm);
  endtask

  task automatic rd_epc(input logic [4:0] a, input logic [31:0] v, input logic [31:0] ep,
                        input string nm);
    rd_push(a, v, ep, 1'b1, nm);
  endtask

  task automatic take_at(input int c, input string nm);
    take_exp_t t;
    t.cyc  = c;
    t.name = nm;
    take_q.push_back(t);
  endtask

  task automatic req(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    exc_req  = 1'b1;
    exc_code = code;
    exc_pc   = pc;
    exc_bd   = bd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    take_exp_t t;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Disturb state, then reset asynchronously mid-cycle.
    wr(5'd12, 32'h0000_0000); step();
    wr(5'd14, 32'h0000_1237); step();
    rd(5'd12, 32'h0000_0000, "sr_write");
    rd(5'd14, 32'h0000_1234, "epc_write_aligned");
    #2 reset = 1'b1;
    rd_epc(5'd12, 32'h0000_FF01, 32'd0, "rst_sr");
    rd(5'd11, CmpRst, "rst_compare");
    rd(5'd13, 32'h0000_0000, "rst_cause");
    reset = 1'b0;
    step();

    // Level line 0: immediate entry, no re-entry while EXL until eret.
    hw_int = 6'b000001;
    exc_pc = 32'h0000_2000;
    take_at(cyc, "level_take");
    step();
    rd(5'd13, 32'h0000_0400, "level_cause");
    rd(5'd12, 32'h0000_FF03, "level_exl");
    rd_epc(5'd14, 32'h0000_2000, 32'h0000_2000, "level_epc");
    eret = 1'b1;
    step();
    take_at(cyc, "level_retake_after_eret");
    step();
    hw_int = 6'b000000;
    eret   = 1'b1;
    step();

    // Exception in a delay slot, then an exception coinciding with an interrupt.
    req(5'd12, 32'h0000_3008, 1'b1);
    take_at(cyc, "exc_take_ov");
    step();
    rd(5'd13, 32'h8000_0030, "exc_cause_bd_ov");
    rd_epc(5'd14, 32'h0000_3004, 32'h0000_3004, "exc_epc_bd");
    eret = 1'b1;
    step();
    hw_int = 6'b000001;
    req(5'd10, 32'h0000_4000, 1'b0);
    take_at(cyc, "int_over_exc_take");
    step();
    hw_int = 6'b000000;
    rd(5'd13, 32'h0000_0400, "int_outranks_exc");
    rd_epc(5'd14, 32'h0000_4000, 32'h0000_4000, "int_exc_epc");
    eret = 1'b1;
    step();

    // Edge line 1 with IE=0: latch, persist, clear, set-beats-clear.
    wr(5'd12, 32'h0000_FF00); step();
    hw_int = 6'b000010; step();
    hw_int = 6'b000000; step();
    rd(5'd13, 32'h0000_0800, "edge_latch");
    rd(5'd13, 32'h0000_0800, "edge_persist");
    wr(5'd13, 32'h0000_0000); step();
    step();
    rd(5'd13, 32'h0000_0000, "edge_clear");
    hw_int = 6'b000010;
    wr(5'd13, 32'h0000_0000); step();
    hw_int = 6'b000000; step();
    rd(5'd13, 32'h0000_0800, "edge_set_wins");
    wr(5'd13, 32'h0000_0000); step();
    step();
    step();
    wr(5'd12, 32'h0000_FF01); step();

`ifdef CP0_TIMER_EN
    // Compare=5, Count=0 at cycle C: match in C+6, entry in C+7.
    wr(5'd11, 32'd5); step();
    wr(5'd9, 32'd0);
    take_at(cyc + 7, "timer_take");
    step();
    step();
    rd(5'd9, 32'd1, "count_run");
    repeat (5) step();
    rd(5'd13, 32'h4000_8000, "timer_cause_ti");
    wr(5'd11, 32'hFFFF_FFFF); step();
    rd(5'd13, 32'h0000_8000, "timer_ti_cleared");
    eret = 1'b1;
    step();
`else
    wr(5'd9, 32'd5); step();
    wr(5'd11, 32'd5); step();
    rd(5'd9, 32'd0, "count_absent");
    rd(5'd11, 32'd0, "compare_absent");
`endif

    // mtc0 coinciding with entry is dropped; eret clears EXL; software interrupt.
    req(5'd4, 32'h0000_5000, 1'b0);
    wr(5'd12, 32'h0000_0000);
    take_at(cyc, "adel_take");
    step();
    rd(5'd12, 32'h0000_FF03, "sr_write_discarded");
    eret = 1'b1;
    step();
    rd(5'd12, 32'h0000_FF01, "eret_clears_exl");
    wr(5'd13, 32'h0000_0100);
    take_at(cyc + 1, "sw_int_take");
    step();
    step();
    rd(5'd13, 32'h0000_0100, "sw_int_cause");
    rd(5'd15, PridVal, "prid");

    repeat (3) step();
    while (take_q.size() > 0) begin
      t = take_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s: exc_take never seen, expected at cycle %0d", t.name, t.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
